hier_node_sequencer: RTL
========================

// Module: hier_node_sequencer
// PURPOSE
//  Parametrised hierarchy node: launches NUM_CHILDREN child instances, tracks
//  their completion and reports one aggregate done to its parent.
//  Runs children concurrently or one at a time in index order, with a
//  per-launch timeout. Replaces fixed-fanout, port-less hierarchy nodes.
// PARAMETERS
//  NUM_CHILDREN  5    child count, 1..32
//  CNT_WIDTH     8    width of timeout counter and cycle counter
//  TIMEOUT       255  WAIT cycles allowed per launch, 1..2**CNT_WIDTH-1
//  SERIAL_MODE   0    0 = concurrent launch; 1 = serial, lowest index first
// PORTS
//  clk            in   1             clock, rising edge
//  rst_n          in   1             asynchronous active-low reset
//  start_i        in   1             run request, sampled only in IDLE
//  en_mask_i      in   NUM_CHILDREN  children to run, sampled with start_i
//  child_start_o  out  NUM_CHILDREN  one-cycle launch pulse per child
//  child_done_i   in   NUM_CHILDREN  one-cycle completion pulse from child
//  busy_o         out  1             high in LAUNCH, WAIT, FINISH
//  done_o         out  1             one-cycle pulse in FINISH
//  done_mask_o    out  NUM_CHILDREN  children completed this run
//  timeout_o      out  1             run ended by timeout
//  cycle_cnt_o    out  CNT_WIDTH     busy cycles this run, saturating
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, internal mask/pointer/counters 0.
//  States: IDLE, LAUNCH, WAIT, FINISH.
//  IDLE: start_i=1 at edge k latches en_mask_i; clears done_mask_o,
//    timeout_o and cycle_cnt_o. Next state LAUNCH (cycle k+1), or FINISH if
//    the latched mask is 0. No child is launched for a zero mask.
//  LAUNCH: one cycle.
//    Concurrent mode: child_start_o = mask.
//    Serial mode: child_start_o = lowest-index bit of mask & ~done_mask.
//    Timeout counter cleared. Next state WAIT.
//  WAIT: done_mask_o |= child_done_i & launched bits.
//    Timeout counter increments each cycle.
//    Concurrent mode: done_mask_o == mask -> FINISH.
//    Serial mode: the active child's done -> LAUNCH if pending bits remain,
//      otherwise FINISH.
//    Counter reaching TIMEOUT-1 with no completion -> timeout_o=1, FINISH.
//  FINISH: done_o=1 for exactly one cycle, then IDLE. done_mask_o and
//    timeout_o hold until the next accepted start.
//  cycle_cnt_o increments every busy cycle and saturates at all-ones.
//  Boundary rules:
//    - start_i outside IDLE is ignored (no queueing).
//    - child_done_i is ignored for bits outside the mask, for children not yet
//      launched, during LAUNCH, and when the bit is already set.
//    - Completion and timeout in the same cycle: completion wins; timeout_o
//      stays 0.
//    - Serial mode: timeout on child j ends the run; children after j are
//      never launched.
//    - Reset during any state returns to IDLE at once, with no done_o pulse.
//  Latency: start at edge k -> child_start_o in cycle k+1 -> WAIT from k+2.
//    Zero mask: done_o in cycle k+1.
// TESTING
//  1. Concurrent, mask=5'b10101; children 0,2,4 signal done at WAIT cycles
//     3,5,7 -> single done_o; done_mask_o=5'b10101; timeout_o=0.
//  2. SERIAL_MODE=1, mask=5'b01110 -> launch order 1,2,3 with one
//     child_start_o bit per LAUNCH; done_o after child 3 completes.
//  3. mask=0 -> no child_start_o; done_o one cycle after start.
//  4. TIMEOUT=16; child 2 never responds -> timeout_o=1 after 16 WAIT
//     cycles; done_mask_o lacks bit 2.
//  5. Spurious done on a disabled child; start_i asserted while busy ->
//     both ignored; done_mask_o unchanged.
//  6. rst_n low mid-WAIT -> all outputs 0 at once; no done_o; a new start
//     after reset runs normally.

Source files
------------

// File: rtl/hier_node_sequencer.sv
// Hierarchy node: launches a masked set of children (concurrently or serially),
// collects their completion pulses and reports one aggregate done with timeout.
module hier_node_sequencer #(
    parameter int unsigned NUM_CHILDREN = 5,
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned SERIAL_MODE  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [NUM_CHILDREN-1:0] en_mask_i,
    output logic [NUM_CHILDREN-1:0] child_start_o,
    input  logic [NUM_CHILDREN-1:0] child_done_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [NUM_CHILDREN-1:0] done_mask_o,
    output logic                    timeout_o,
    output logic [CNT_WIDTH-1:0]    cycle_cnt_o
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

    state_t                  state_q, state_d;
    logic [NUM_CHILDREN-1:0] mask_q;
    logic [NUM_CHILDREN-1:0] active_q;
    logic [CNT_WIDTH-1:0]    tmo_q;

    logic [NUM_CHILDREN-1:0] pending;
    logic [NUM_CHILDREN-1:0] lowest;
    logic [NUM_CHILDREN-1:0] launch_bits;
    logic [NUM_CHILDREN-1:0] accept;
    logic [NUM_CHILDREN-1:0] done_new;
    logic                    found;
    logic                    complete;
    logic                    tmo_hit;

    always_comb begin
        pending = mask_q & ~done_mask_o;
        lowest  = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
            if (pending[i] && !found) begin
                lowest[i] = 1'b1;
                found     = 1'b1;
            end
        end
        launch_bits = (SERIAL_MODE != 0) ? lowest : mask_q;
        // In serial mode only the child currently running may report completion.
        accept      = (SERIAL_MODE != 0) ? active_q : mask_q;
        done_new    = done_mask_o | (child_done_i & accept);
        complete    = (SERIAL_MODE != 0) ? |(child_done_i & active_q)
                                         : (done_new == mask_q);
        tmo_hit     = (tmo_q == CNT_WIDTH'(TIMEOUT - 1));

        state_d       = state_q;
        child_start_o = '0;
        done_o        = 1'b0;
        busy_o        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (en_mask_i == '0) ? FINISH : LAUNCH;
                end
            end
            LAUNCH: begin
                child_start_o = launch_bits;
                state_d       = WAIT;
            end
            WAIT: begin
                if (complete) begin
                    state_d = ((SERIAL_MODE != 0) && |(mask_q & ~done_new)) ? LAUNCH : FINISH;
                end else if (tmo_hit) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            active_q    <= '0;
            tmo_q       <= '0;
            done_mask_o <= '0;
            timeout_o   <= 1'b0;
            cycle_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != IDLE && cycle_cnt_o != '1) begin
                cycle_cnt_o <= cycle_cnt_o + CNT_WIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mask_q      <= en_mask_i;
                        active_q    <= '0;
                        done_mask_o <= '0;
                        timeout_o   <= 1'b0;
                        cycle_cnt_o <= '0;
                    end
                end
                LAUNCH: begin
                    tmo_q    <= '0;
                    active_q <= launch_bits;
                end
                WAIT: begin
                    done_mask_o <= done_new;
                    tmo_q       <= tmo_q + CNT_WIDTH'(1);
                    if (!complete && tmo_hit) begin
                        timeout_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
